// File: rtl/uib_mem_arbiter_if.sv
// UIB arbiter bus bundle: N master-side request lanes plus the single memory-slave port.
// Latency: none, wires only.
// Backpressure: m_ready is the only accept signal; the slave port never stalls.
interface uib_mem_arbiter_if #(
  parameter int N_MST  = 2,
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int MODE_W = 2
);
  // requester side, flattened: lane i at [i*W +: W]
  logic [N_MST-1:0]        m_req;
  logic [N_MST-1:0]        m_wen;
  logic [N_MST*ADDR_W-1:0] m_addr;
  logic [N_MST*MODE_W-1:0] m_mode;
  logic [N_MST*XLEN-1:0]   m_dat_w;
  logic [N_MST-1:0]        m_ready;
  logic [N_MST-1:0]        m_rvalid;
  logic [XLEN-1:0]         m_dat_r;

  // memory slave side
  logic                    s_req;
  logic                    s_wen;
  logic [ADDR_W-1:0]       s_addr;
  logic [MODE_W-1:0]       s_mode;
  logic [XLEN-1:0]         s_dat_o;
  logic [XLEN-1:0]         s_dat_i;

  // arbiter view: it is the slave of the requesters and drives the memory port
  modport slave (
    input  m_req, m_wen, m_addr, m_mode, m_dat_w, s_dat_i,
    output m_ready, m_rvalid, m_dat_r, s_req, s_wen, s_addr, s_mode, s_dat_o
  );

  // environment view: requesters plus the memory model
  modport master (
    output m_req, m_wen, m_addr, m_mode, m_dat_w, s_dat_i,
    input  m_ready, m_rvalid, m_dat_r, s_req, s_wen, s_addr, s_mode, s_dat_o
  );
endinterface

// File: rtl/uib_mem_arbiter.sv
// Round-robin arbiter sharing one UIB memory slave between N_MST masters, one op in flight.
// Latency: accept T, issue T+1, capture after RD_LAT WAIT cycles, m_rvalid at T+2+RD_LAT.
// Backpressure: m_ready only in IDLE for the winner; requests wait (held by masters) otherwise.
module uib_mem_arbiter #(
  parameter int N_MST  = 2,
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int MODE_W = 2,
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  uib_mem_arbiter_if.slave   bus
);
  localparam int PTR_W = $clog2(N_MST);
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic               wen_q, wen_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [MODE_W-1:0]  mode_q, mode_d;
  logic [XLEN-1:0]    dat_w_q, dat_w_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_MST-1:0]   rvalid_q, rvalid_d;
  logic [XLEN-1:0]    dat_r_q, dat_r_d;

  logic [N_MST-1:0]   req_rot;
  logic               found;
  logic [PTR_W:0]     win_sum;
  logic [PTR_W-1:0]   winner;
  logic [N_MST-1:0]   ready_c;

  // pick the first requester at or after rr_ptr, wrapping modulo N_MST
  always_comb begin
    req_rot = N_MST'({bus.m_req, bus.m_req} >> rr_ptr_q);
    found   = 1'b0;
    win_sum = {1'b0, rr_ptr_q};
    for (int k = 0; k < N_MST; k++) begin
      if (!found && req_rot[k]) begin
        found   = 1'b1;
        win_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      end
    end
    if (win_sum >= (PTR_W+1)'(N_MST)) begin
      win_sum = win_sum - (PTR_W+1)'(N_MST);
    end
    winner = win_sum[PTR_W-1:0];
  end

  // next-state, request latch, latency countdown and completion
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    wen_d    = wen_q;
    addr_d   = addr_q;
    mode_d   = mode_q;
    dat_w_d  = dat_w_q;
    cnt_d    = cnt_q;
    rvalid_d = '0;
    dat_r_d  = dat_r_q;
    ready_c  = '0;
    case (state_q)
      IDLE: begin
        // gated by rst so nothing is accepted in a cycle that is being reset
        if (found && !rst) begin
          ready_c = N_MST'(1) << winner;
          owner_d = winner;
          for (int i = 0; i < N_MST; i++) begin
            if (winner == PTR_W'(i)) begin
              wen_d   = bus.m_wen[i];
              addr_d  = bus.m_addr[i*ADDR_W +: ADDR_W];
              mode_d  = bus.m_mode[i*MODE_W +: MODE_W];
              dat_w_d = bus.m_dat_w[i*XLEN +: XLEN];
            end
          end
          rr_ptr_d = (winner == PTR_W'(N_MST-1)) ? '0 : winner + 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(RD_LAT);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          if (!wen_q) begin
            dat_r_d = bus.s_dat_i;
          end
          rvalid_d = N_MST'(1) << owner_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers; reset aborts any in-flight op
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      mode_q   <= '0;
      dat_w_q  <= '0;
      cnt_q    <= '0;
      rvalid_q <= '0;
      dat_r_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      wen_q    <= wen_d;
      addr_q   <= addr_d;
      mode_q   <= mode_d;
      dat_w_q  <= dat_w_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      dat_r_q  <= dat_r_d;
    end
  end

  // slave port is driven only during the single ISSUE cycle
  always_comb begin
    bus.s_req   = 1'b0;
    bus.s_wen   = 1'b0;
    bus.s_addr  = '0;
    bus.s_mode  = '0;
    bus.s_dat_o = '0;
    if (state_q == ISSUE) begin
      bus.s_req   = 1'b1;
      bus.s_wen   = wen_q;
      bus.s_addr  = addr_q;
      bus.s_mode  = mode_q;
      bus.s_dat_o = dat_w_q;
    end
  end

  assign bus.m_ready  = ready_c;
  assign bus.m_rvalid = rvalid_q;
  assign bus.m_dat_r  = dat_r_q;
endmodule

// File: tb/tb_uib_mem_arbiter.sv
// Directed bench for uib_mem_arbiter: three instances (2 masters/lat 1, 2 masters/lat 3, 3 masters/lat 1).
// Latency: expected cycle positions are hand-derived from the accept cycle T.
// Backpressure: memory models return garbage except in the exact capture cycle.
module tb_uib_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  uib_mem_arbiter_if #(.N_MST(2)) ifa ();
  uib_mem_arbiter_if #(.N_MST(2)) ifb ();
  uib_mem_arbiter_if #(.N_MST(3)) ifc ();

  uib_mem_arbiter #(.N_MST(2), .RD_LAT(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  uib_mem_arbiter #(.N_MST(2), .RD_LAT(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  uib_mem_arbiter #(.N_MST(3), .RD_LAT(1)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : {16'hA5A5, a[15:0]};
  endfunction

  // memory models: one remembered write, read data valid only RD_LAT cycles after issue
  logic [31:0] wa_a, wd_a, rd_a, wa_b, wd_b, rd_b, wa_c, wd_c, rd_c;
  logic        wv_a, wv_b, wv_c;
  logic [3:0]  rv_a, rv_b, rv_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      rv_a <= '0; wv_a <= 1'b0; rv_b <= '0; wv_b <= 1'b0; rv_c <= '0; wv_c <= 1'b0;
    end else begin
      rv_a <= {rv_a[2:0], ifa.s_req & ~ifa.s_wen};
      rv_b <= {rv_b[2:0], ifb.s_req & ~ifb.s_wen};
      rv_c <= {rv_c[2:0], ifc.s_req & ~ifc.s_wen};
      if (ifa.s_req && ifa.s_wen) begin wv_a <= 1'b1; wa_a <= ifa.s_addr; wd_a <= ifa.s_dat_o; end
      if (ifb.s_req && ifb.s_wen) begin wv_b <= 1'b1; wa_b <= ifb.s_addr; wd_b <= ifb.s_dat_o; end
      if (ifc.s_req && ifc.s_wen) begin wv_c <= 1'b1; wa_c <= ifc.s_addr; wd_c <= ifc.s_dat_o; end
    end
    if (ifa.s_req && !ifa.s_wen) rd_a <= (wv_a && ifa.s_addr == wa_a) ? wd_a : rom(ifa.s_addr);
    if (ifb.s_req && !ifb.s_wen) rd_b <= (wv_b && ifb.s_addr == wa_b) ? wd_b : rom(ifb.s_addr);
    if (ifc.s_req && !ifc.s_wen) rd_c <= (wv_c && ifc.s_addr == wa_c) ? wd_c : rom(ifc.s_addr);
  end

  assign ifa.s_dat_i = rv_a[0] ? rd_a : 32'hBAD0BAD0;
  assign ifb.s_dat_i = rv_b[2] ? rd_b : 32'hBAD0BAD0;
  assign ifc.s_dat_i = rv_c[0] ? rd_c : 32'hBAD0BAD0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    ifa.m_req = '0; ifa.m_wen = '0; ifa.m_addr = '0; ifa.m_mode = '0; ifa.m_dat_w = '0;
    ifb.m_req = '0; ifb.m_wen = '0; ifb.m_addr = '0; ifb.m_mode = '0; ifb.m_dat_w = '0;
    ifc.m_req = '0; ifc.m_wen = '0; ifc.m_addr = '0; ifc.m_mode = '0; ifc.m_dat_w = '0;

    // reset values
    cyc(); cyc(); rst = 1'b0; #2;
    check("rst_ready",  ifa.m_ready,  2'b00);
    check("rst_rvalid", ifa.m_rvalid, 2'b00);
    check("rst_dat_r",  ifa.m_dat_r,  32'h0);
    check("rst_s_req",  ifa.s_req,    1'b0);
    check("rst_s_addr", ifa.s_addr,   32'h0);

    // single read, master 0, addr 0x10, word mode
    cyc(); ifa.m_req = 2'b01; ifa.m_addr[31:0] = 32'h10; ifa.m_mode[1:0] = 2'b10; #2;
    check("rd_ready_T", ifa.m_ready, 2'b01);
    check("rd_sreq_T",  ifa.s_req,   1'b0);
    cyc(); ifa.m_req = 2'b00; #2;
    check("rd_sreq_T1",  ifa.s_req,   1'b1);
    check("rd_saddr_T1", ifa.s_addr,  32'h10);
    check("rd_smode_T1", ifa.s_mode,  2'b10);
    check("rd_swen_T1",  ifa.s_wen,   1'b0);
    check("rd_ready_T1", ifa.m_ready, 2'b00);
    cyc(); #2;
    check("rd_sreq_T2",   ifa.s_req,    1'b0);
    check("rd_rvalid_T2", ifa.m_rvalid, 2'b00);
    cyc(); #2;
    check("rd_rvalid_T3", ifa.m_rvalid, 2'b01);
    check("rd_dat_T3",    ifa.m_dat_r,  32'hDEADBEEF);
    cyc(); #2;
    check("rd_rvalid_T4", ifa.m_rvalid, 2'b00);
    check("rd_dat_T4",    ifa.m_dat_r,  32'hDEADBEEF);

    // write by master 1, then read back
    cyc(); ifa.m_req = 2'b10; ifa.m_wen = 2'b10; ifa.m_addr[63:32] = 32'h20;
    ifa.m_mode[3:2] = 2'b10; ifa.m_dat_w[63:32] = 32'h12345678; #2;
    check("wr_ready", ifa.m_ready, 2'b10);
    cyc(); ifa.m_req = 2'b00; #2;
    check("wr_sreq",  ifa.s_req,   1'b1);
    check("wr_swen",  ifa.s_wen,   1'b1);
    check("wr_saddr", ifa.s_addr,  32'h20);
    check("wr_sdat",  ifa.s_dat_o, 32'h12345678);
    cyc(); #2;
    check("wr_sreq_off", ifa.s_req, 1'b0);
    check("wr_swen_off", ifa.s_wen, 1'b0);
    cyc(); ifa.m_req = 2'b10; ifa.m_wen = 2'b00; #2;
    check("wr_rvalid",     ifa.m_rvalid, 2'b10);
    check("wr_dat_kept",   ifa.m_dat_r,  32'hDEADBEEF);
    check("rb_ready_same", ifa.m_ready,  2'b10);
    cyc(); ifa.m_req = 2'b00; #2;
    check("rb_sreq",  ifa.s_req,  1'b1);
    check("rb_saddr", ifa.s_addr, 32'h20);
    check("rb_swen",  ifa.s_wen,  1'b0);
    cyc(); cyc(); #2;
    check("rb_rvalid", ifa.m_rvalid, 2'b10);
    check("rb_dat",    ifa.m_dat_r,  32'h12345678);

    // contention: both masters request from reset onward
    cyc(); rst = 1'b1; ifa.m_req = 2'b11; ifa.m_addr = {32'h20, 32'h10};
    cyc(); cyc(); rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      #2;
      check($sformatf("cont_ready_%0d", k), ifa.m_ready,
            (k % 3 != 0) ? 2'b00 : (((k / 3) % 2 == 0) ? 2'b01 : 2'b10));
      check($sformatf("cont_rvalid_%0d", k), ifa.m_rvalid,
            (k % 3 != 0 || k == 0) ? 2'b00 : (((k / 3) % 2 == 1) ? 2'b01 : 2'b10));
      if (k % 3 == 0 && k > 0)
        check($sformatf("cont_dat_%0d", k), ifa.m_dat_r,
              ((k / 3) % 2 == 1) ? 32'hDEADBEEF : 32'hA5A50020);
      cyc();
    end
    ifa.m_req = 2'b00;
    cyc(); cyc();

    // reset during WAIT aborts the op
    cyc(); ifa.m_req = 2'b01; #2;
    check("ab_ready", ifa.m_ready, 2'b01);
    cyc(); ifa.m_req = 2'b00;
    cyc(); rst = 1'b1; #2;
    check("ab_sreq_wait", ifa.s_req, 1'b0);
    cyc(); rst = 1'b0; ifa.m_req = 2'b01; #2;
    check("ab_rvalid", ifa.m_rvalid, 2'b00);
    check("ab_sreq",   ifa.s_req,    1'b0);
    check("ab_dat",    ifa.m_dat_r,  32'h0);
    check("ab_idle",   ifa.m_ready,  2'b01);
    cyc(); ifa.m_req = 2'b00; #2;
    check("ab_no_rv", ifa.m_rvalid, 2'b00);
    cyc(); cyc(); #2;
    check("ab_rvalid_new", ifa.m_rvalid, 2'b01);
    check("ab_dat_new",    ifa.m_dat_r,  32'hDEADBEEF);

    // RD_LAT=3 single read
    cyc(); ifb.m_req = 2'b01; ifb.m_addr[31:0] = 32'h10; #2;
    check("lat_ready", ifb.m_ready, 2'b01);
    cyc(); ifb.m_req = 2'b00; #2;
    check("lat_sreq",  ifb.s_req,  1'b1);
    check("lat_saddr", ifb.s_addr, 32'h10);
    for (int k = 2; k <= 4; k++) begin
      cyc(); #2;
      check($sformatf("lat_sreq_%0d", k),   ifb.s_req,    1'b0);
      check($sformatf("lat_rvalid_%0d", k), ifb.m_rvalid, 2'b00);
    end
    cyc(); #2;
    check("lat_rvalid_5", ifb.m_rvalid, 2'b01);
    check("lat_dat_5",    ifb.m_dat_r,  32'hDEADBEEF);
    cyc(); #2;
    check("lat_rvalid_6", ifb.m_rvalid, 2'b00);

    // N_MST=3: move rr_ptr to 1, then masters 0 and 2 contend
    cyc(); ifc.m_req = 3'b001; ifc.m_addr[31:0] = 32'h40; #2;
    check("rr3_ready0", ifc.m_ready, 3'b001);
    cyc(); ifc.m_req = 3'b000;
    cyc(); cyc(); ifc.m_req = 3'b101; ifc.m_addr[95:64] = 32'h10; #2;
    check("rr3_rvalid0", ifc.m_rvalid, 3'b001);
    check("rr3_dat0",    ifc.m_dat_r,  32'hA5A50040);
    check("rr3_ready2",  ifc.m_ready,  3'b100);
    cyc(); ifc.m_req = 3'b001; #2;
    check("rr3_busy",  ifc.m_ready, 3'b000);
    check("rr3_saddr", ifc.s_addr,  32'h10);
    cyc(); cyc(); #2;
    check("rr3_rvalid2", ifc.m_rvalid, 3'b100);
    check("rr3_dat2",    ifc.m_dat_r,  32'hDEADBEEF);
    check("rr3_ready0b", ifc.m_ready,  3'b001);
    cyc(); ifc.m_req = 3'b000;
    cyc(); cyc(); #2;
    check("rr3_rvalid0b", ifc.m_rvalid, 3'b001);
    check("rr3_dat0b",    ifc.m_dat_r,  32'hA5A50040);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
